// File: rtl/video_pkg.sv
// Shared video timing defaults, luma levels and the box descriptor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package video_pkg;

  // NTSC 525/60 field timing at one sample per active pixel.
  localparam int H_ACTIVE_DEF = 720;
  localparam int H_TOTAL_DEF  = 858;
  localparam int V_BLANK_DEF  = 22;
  localparam int V_TOTAL_DEF  = 262;
  localparam int PIX_DIV_DEF  = 2;

  localparam logic [7:0] LUMA_WHITE = 8'hEB;
  localparam logic [7:0] LUMA_BLACK = 8'h10;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } box_t;

  // One bounce step along one axis. Returns {dir_neg, new_pos}.
  // The box keeps its direction while its far edge stays inside [0, limit),
  // otherwise it turns round; a box that fits neither way stays put.
  function automatic logic [10:0] bounce_step(
    input logic [9:0]  pos,
    input logic [9:0]  size,
    input logic        dir_neg,
    input logic [10:0] limit
  );
    logic        can_inc;
    logic        can_dec;
    logic [10:0] res;
    can_inc = (({1'b0, pos} + {1'b0, size}) < limit);
    can_dec = (pos != 10'd0);
    res     = {dir_neg, pos};
    if (!dir_neg) begin
      if (can_inc)      res = {1'b0, pos + 10'd1};
      else if (can_dec) res = {1'b1, pos - 10'd1};
    end else begin
      if (can_dec)      res = {1'b1, pos - 10'd1};
      else if (can_inc) res = {1'b0, pos + 10'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Pixel divider plus hc/vc/field raster counters and blanking flags.
// Latency: flags are combinational from the counter registers.
// Backpressure: none, free-running raster.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_BLANK  = V_BLANK_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int PIX_DIV  = PIX_DIV_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_stb,
  output logic [9:0] o_hc,
  output logic [9:0] o_vc,
  output logic       o_field,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic       o_f0_wrap
);

  localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       HC_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]       VC_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]       HC_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]       VC_BLANK = 10'(V_BLANK);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic             r_field;
  logic             w_stb;
  logic             w_hc_wrap;
  logic             w_vc_wrap;

  assign w_stb     = (r_div == DIV_LAST);
  assign w_hc_wrap = w_stb && (r_hc == HC_LAST);
  assign w_vc_wrap = w_hc_wrap && (r_vc == VC_LAST);

  // Divider and raster counters; hc/vc/field only move on the pixel strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div   <= '0;
      r_hc    <= '0;
      r_vc    <= '0;
      r_field <= 1'b0;
    end else begin
      r_div <= w_stb ? '0 : r_div + DIV_W'(1);
      if (w_stb) begin
        r_hc <= w_hc_wrap ? 10'd0 : r_hc + 10'd1;
        if (w_hc_wrap) begin
          r_vc <= w_vc_wrap ? 10'd0 : r_vc + 10'd1;
        end
        if (w_vc_wrap) begin
          r_field <= ~r_field;
        end
      end
    end
  end

  assign o_stb     = w_stb;
  assign o_hc      = r_hc;
  assign o_vc      = r_vc;
  assign o_field   = r_field;
  assign o_hblank  = (r_hc >= HC_ACT);
  assign o_vblank  = (r_vc < VC_BLANK);
  // Last pixel of field 1: the clock on which the raster wraps into field 0.
  assign o_f0_wrap = w_vc_wrap && r_field;

endmodule

// File: rtl/ntsc_pattern_gen.sv
// Synthetic decoder-format source: one white box per frame plus its expected centroid/count.
// Latency: fvh/dv/dout registered one clk after the pixel strobe; exp_* with the field-0 start.
// Backpressure: cfg_ready drops on accept and returns at the field-0 wrap (macro PATGEN_BOUNCE_EN adds box bounce).
module ntsc_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_BLANK  = V_BLANK_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int PIX_DIV  = PIX_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [9:0]  box_x,
  input  logic [9:0]  box_y,
  input  logic [9:0]  box_w,
  input  logic [9:0]  box_h,
  output logic [2:0]  fvh,
  output logic        dv,
  output logic [7:0]  dout,
  output logic        exp_valid,
  output logic [9:0]  exp_cx,
  output logic [9:0]  exp_cy,
  output logic [19:0] exp_count
);

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_TOTAL - V_BLANK);
  localparam logic [9:0]  ROW_OFS = 10'(V_BLANK);

  logic        w_stb;
  logic [9:0]  w_hc;
  logic [9:0]  w_vc;
  logic        w_field;
  logic        w_hblank;
  logic        w_vblank;
  logic        w_f0_wrap;

  box_t        r_active;
  box_t        r_shadow;
  logic        r_cfg_ready;
  logic [2:0]  r_fvh;
  logic        r_dv;
  logic [7:0]  r_dout;
  logic        r_exp_valid;
  logic [9:0]  r_exp_cx;
  logic [9:0]  r_exp_cy;
  logic [19:0] r_exp_count;

  logic [9:0]  w_row;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_inside;
  logic [10:0] w_x1;
  logic [10:0] w_y1;
  logic        w_empty;
  logic [10:0] w_cx_sum;
  logic [10:0] w_cy_sum;
  logic [10:0] w_span_x;
  logic [10:0] w_span_y;
  logic [19:0] w_count;
  logic        w_f0_start;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_BLANK  (V_BLANK),
    .V_TOTAL  (V_TOTAL),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .i_clk     (clk),
    .i_reset   (reset),
    .o_stb     (w_stb),
    .o_hc      (w_hc),
    .o_vc      (w_vc),
    .o_field   (w_field),
    .o_hblank  (w_hblank),
    .o_vblank  (w_vblank),
    .o_f0_wrap (w_f0_wrap)
  );

  // Box hit test on the pixel currently named by the counters. Ends are
  // 11-bit so a box near the 10-bit limit never wraps back on screen.
  assign w_row    = w_vc - ROW_OFS;
  assign w_x_end  = {1'b0, r_active.x} + {1'b0, r_active.w};
  assign w_y_end  = {1'b0, r_active.y} + {1'b0, r_active.h};
  assign w_inside = (w_hc >= r_active.x) && ({1'b0, w_hc} < w_x_end) &&
                    (w_row >= r_active.y) && ({1'b0, w_row} < w_y_end);

  // Expected centroid/count of the box after clipping to the active area.
  assign w_x1       = (w_x_end > H_LIM) ? H_LIM : w_x_end;
  assign w_y1       = (w_y_end > V_LIM) ? V_LIM : w_y_end;
  assign w_empty    = (r_active.w == 10'd0) || (r_active.h == 10'd0) ||
                      ({1'b0, r_active.x} >= H_LIM) || ({1'b0, r_active.y} >= V_LIM);
  assign w_cx_sum   = {1'b0, r_active.x} + w_x1 - 11'd1;
  assign w_cy_sum   = {1'b0, r_active.y} + w_y1 - 11'd1;
  assign w_span_x   = w_x1 - {1'b0, r_active.x};
  assign w_span_y   = w_y1 - {1'b0, r_active.y};
  assign w_count    = 20'(w_span_x) * 20'(w_span_y);
  assign w_f0_start = w_stb && (w_hc == 10'd0) && (w_vc == 10'd0) && !w_field;

`ifdef PATGEN_BOUNCE_EN
  logic        r_dir_x;
  logic        r_dir_y;
  logic [10:0] w_step_x;
  logic [10:0] w_step_y;

  assign w_step_x = bounce_step(r_active.x, r_active.w, r_dir_x, H_LIM);
  assign w_step_y = bounce_step(r_active.y, r_active.h, r_dir_y, V_LIM);
`endif

  // Config handshake: shadow capture, frame-aligned swap into the active box.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= '0;
      r_shadow    <= '0;
      r_cfg_ready <= 1'b1;
`ifdef PATGEN_BOUNCE_EN
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
`endif
    end else if (w_f0_wrap && !r_cfg_ready) begin
      r_active    <= r_shadow;
      r_cfg_ready <= 1'b1;
`ifdef PATGEN_BOUNCE_EN
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
`endif
    end else begin
      // A strobe landing on the wrap itself is only shadowed, so it waits a frame.
      if (cfg_valid && r_cfg_ready) begin
        r_shadow    <= '{x: box_x, y: box_y, w: box_w, h: box_h};
        r_cfg_ready <= 1'b0;
      end
`ifdef PATGEN_BOUNCE_EN
      if (w_f0_wrap) begin
        r_active.x <= w_step_x[9:0];
        r_active.y <= w_step_y[9:0];
        r_dir_x    <= w_step_x[10];
        r_dir_y    <= w_step_y[10];
      end
`endif
    end
  end

  // Video outputs: flags follow every strobe, luma only changes on active pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fvh  <= 3'b010;
      r_dv   <= 1'b0;
      r_dout <= LUMA_BLACK;
    end else begin
      r_dv <= 1'b0;
      if (w_stb) begin
        r_fvh <= {w_field, w_vblank, w_hblank};
        if (!w_hblank && !w_vblank) begin
          r_dv   <= 1'b1;
          r_dout <= w_inside ? LUMA_WHITE : LUMA_BLACK;
        end
      end
    end
  end

  // Expected values latch alongside the field-0 start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp_valid <= 1'b0;
      r_exp_cx    <= '0;
      r_exp_cy    <= '0;
      r_exp_count <= '0;
    end else begin
      r_exp_valid <= w_f0_start;
      if (w_f0_start) begin
        r_exp_cx    <= w_empty ? 10'd0 : 10'(w_cx_sum >> 1);
        r_exp_cy    <= w_empty ? 10'd0 : 10'(w_cy_sum >> 1);
        r_exp_count <= w_empty ? 20'd0 : w_count;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign fvh       = r_fvh;
  assign dv        = r_dv;
  assign dout      = r_dout;
  assign exp_valid = r_exp_valid;
  assign exp_cx    = r_exp_cx;
  assign exp_cy    = r_exp_cy;
  assign exp_count = r_exp_count;

endmodule

// File: tb/tb_ntsc_pattern_gen.sv
// Bench for ntsc_pattern_gen on a shrunken raster so whole frames run quickly.
// Reference is a pixel-index model: clock count -> pixel -> (field, line, column).
// Directed boxes pin literal expectations; random configs exercise the handshake.
module tb_ntsc_pattern_gen;

  localparam int HA = 16;
  localparam int HT = 20;
  localparam int VB = 2;
  localparam int VT = 14;
  localparam int PD = 2;
  localparam int VA = VT - VB;
  localparam int FP = HT * VT;
  localparam int FIELD_CYC = FP * PD;
  localparam int FRAME_CYC = 2 * FIELD_CYC;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [9:0]  box_x, box_y, box_w, box_h;
  logic [2:0]  fvh;
  logic        dv;
  logic [7:0]  dout;
  logic        exp_valid;
  logic [9:0]  exp_cx, exp_cy;
  logic [19:0] exp_count;

  int checks = 0;
  int failures = 0;

  ntsc_pattern_gen #(
    .H_ACTIVE (HA), .H_TOTAL (HT), .V_BLANK (VB), .V_TOTAL (VT), .PIX_DIV (PD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .box_x     (box_x),
    .box_y     (box_y),
    .box_w     (box_w),
    .box_h     (box_h),
    .fvh       (fvh),
    .dv        (dv),
    .dout      (dout),
    .exp_valid (exp_valid),
    .exp_cx    (exp_cx),
    .exp_cy    (exp_cy),
    .exp_count (exp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   k;                       // clocks since reset released
  int   ax, ay, aw, ah;          // box being drawn
  int   px, py, pw, ph;          // pending box
  bit   m_pend;
  bit   dxn, dyn;                // bounce directions (1 = moving toward 0)
  logic [2:0] m_fvh;
  bit   m_dv, m_ev, m_ready, m_started;
  logic [7:0] m_dout;
  int   m_cx, m_cy, m_cnt;
  int   p, f, rem, vc, hc, x1, y1;
  bit   accept, wrap;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (reset) begin
      k = 0; ax = 0; ay = 0; aw = 0; ah = 0; px = 0; py = 0; pw = 0; ph = 0;
      m_pend = 0; dxn = 0; dyn = 0;
      m_fvh = 3'b010; m_dv = 0; m_dout = 8'h10; m_ev = 0;
      m_cx = 0; m_cy = 0; m_cnt = 0; m_ready = 1;
    end else begin
      accept = cfg_valid && !m_pend;
      wrap = 0;
      k = k + 1;
      m_dv = 0;
      m_ev = 0;
      if (k % PD == 0) begin
        p   = k / PD - 1;
        f   = (p / FP) % 2;
        rem = p % FP;
        vc  = rem / HT;
        hc  = rem % HT;
        m_fvh = {f[0], vc < VB, hc >= HA};
        if (vc >= VB && hc < HA) begin
          m_dv = 1;
          m_dout = (hc >= ax && hc < ax + aw && vc - VB >= ay && vc - VB < ay + ah) ? 8'hEB : 8'h10;
        end
        if (f == 0 && rem == 0) begin
          m_ev = 1;
          x1 = (ax + aw < HA) ? ax + aw : HA;
          y1 = (ay + ah < VA) ? ay + ah : VA;
          if (aw == 0 || ah == 0 || ax >= HA || ay >= VA) begin
            m_cx = 0; m_cy = 0; m_cnt = 0;
          end else begin
            m_cx = (ax + x1 - 1) / 2;
            m_cy = (ay + y1 - 1) / 2;
            m_cnt = (x1 - ax) * (y1 - ay);
          end
        end
        wrap = (f == 1 && rem == FP - 1);
      end
      if (wrap && m_pend) begin
        ax = px; ay = py; aw = pw; ah = ph; m_pend = 0; dxn = 0; dyn = 0;
      end else begin
        if (accept) begin
          px = box_x; py = box_y; pw = box_w; ph = box_h; m_pend = 1;
        end
`ifdef PATGEN_BOUNCE_EN
        if (wrap) begin
          if (!dxn) begin
            if (ax + aw < HA) ax++; else if (ax > 0) begin ax--; dxn = 1; end
          end else begin
            if (ax > 0) ax--; else if (ax + aw < HA) begin ax++; dxn = 0; end
          end
          if (!dyn) begin
            if (ay + ah < VA) ay++; else if (ay > 0) begin ay--; dyn = 1; end
          end else begin
            if (ay > 0) ay--; else if (ay + ah < VA) begin ay++; dyn = 0; end
          end
        end
`endif
      end
      m_ready = !m_pend;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("fvh", int'(fvh), int'(m_fvh));
      chk("dv", int'(dv), int'(m_dv));
      chk("dout", int'(dout), int'(m_dout));
      chk("cfg_ready", int'(cfg_ready), int'(m_ready));
      chk("exp_valid", int'(exp_valid), int'(m_ev));
      chk("exp_cx", int'(exp_cx), m_cx);
      chk("exp_cy", int'(exp_cy), m_cy);
      chk("exp_count", int'(exp_count), m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input int x, input int y, input int w, input int h);
    box_x = 10'(x); box_y = 10'(y); box_w = 10'(w); box_h = 10'(h);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_exp(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (exp_valid) seen = 1;
    end
    if (!seen) chk("exp_valid_timeout", 0, 1);
  endtask

  task automatic measure_field(output int ndv, output int neb, output int first);
    ndv = 0; neb = 0; first = -1;
    for (int i = 0; i < FIELD_CYC; i++) begin
      @(negedge clk);
      if (dv) begin
        if (first < 0) first = int'(dout);
        ndv++;
        if (dout == 8'hEB) neb++;
      end
    end
  endtask

  int ndv, neb, first;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0;
    box_x = '0; box_y = '0; box_w = '0; box_h = '0;
    repeat (3) @(negedge clk);
    chk("rst_fvh", int'(fvh), 2);
    chk("rst_dv", int'(dv), 0);
    chk("rst_dout", int'(dout), 16);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_exp_count", int'(exp_count), 0);
    reset = 1'b0;

    // Empty box: full field of black active pixels.
    wait_exp(50);
    chk("blank_exp_count", int'(exp_count), 0);
    measure_field(ndv, neb, first);
    chk("blank_dv_per_field", ndv, HA * VA);
    chk("blank_white_pixels", neb, 0);

    // Interior box.
    cfg(5, 3, 4, 2);
    wait_exp(2 * FRAME_CYC);
    chk("box1_cx", int'(exp_cx), 6);
    chk("box1_cy", int'(exp_cy), 3);
    chk("box1_count", int'(exp_count), 8);
    measure_field(ndv, neb, first);
    chk("box1_white_pixels", neb, 8);
    chk("box1_dv_per_field", ndv, HA * VA);

    // Single top-left pixel.
    cfg(0, 0, 1, 1);
    wait_exp(2 * FRAME_CYC);
    chk("px_cx", int'(exp_cx), 0);
    chk("px_cy", int'(exp_cy), 0);
    chk("px_count", int'(exp_count), 1);
    measure_field(ndv, neb, first);
    chk("px_first_dout", first, 235);
    chk("px_white_pixels", neb, 1);

    // Box clipped by right and bottom edges to 3x2.
    cfg(13, 10, 10, 10);
    wait_exp(2 * FRAME_CYC);
    chk("clip_cx", int'(exp_cx), 14);
    chk("clip_cy", int'(exp_cy), 10);
    chk("clip_count", int'(exp_count), 6);
    measure_field(ndv, neb, first);
    chk("clip_white_pixels", neb, 6);

    // Mid-field-1 config; a second offer while busy is ignored.
    repeat (FIELD_CYC / 2) @(negedge clk);
    cfg(2, 2, 3, 3);
    chk("mid_ready_low", int'(cfg_ready), 0);
    cfg(8, 8, 2, 2);
    chk("mid_ready_still_low", int'(cfg_ready), 0);
    wait_exp(2 * FRAME_CYC);
    chk("mid_cx", int'(exp_cx), 3);
    chk("mid_cy", int'(exp_cy), 3);
    chk("mid_count", int'(exp_count), 9);
    chk("mid_ready_back", int'(cfg_ready), 1);

    // Offer landing exactly on the field-0 wrap clock: shadowed, applied a frame later.
    repeat (FRAME_CYC - PD - 1) @(negedge clk);
    cfg(4, 1, 2, 5);
    chk("wrap_cfg_accepted", int'(cfg_ready), 0);
    wait_exp(2 * FRAME_CYC);
`ifndef PATGEN_BOUNCE_EN
    chk("wrap_old_count", int'(exp_count), 9);
`endif
    wait_exp(2 * FRAME_CYC);
    chk("wrap_new_cx", int'(exp_cx), 4);
    chk("wrap_new_cy", int'(exp_cy), 3);
    chk("wrap_new_count", int'(exp_count), 10);

    // Random boxes at random times, some far off screen.
    for (int r = 0; r < 12; r++) begin
      int x, y, w, h;
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      x = $urandom_range(0, 20);
      y = $urandom_range(0, 16);
      w = $urandom_range(0, 10);
      h = $urandom_range(0, 10);
      if ($urandom_range(0, 3) == 0) x = 1000 + $urandom_range(0, 23);
      cfg(x, y, w, h);
    end
    repeat (FRAME_CYC) @(negedge clk);

    // Reset mid-line with a pending config: everything back to reset values.
    if (cfg_ready) cfg(7, 7, 3, 3);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_fvh", int'(fvh), 2);
    chk("mid_rst_dv", int'(dv), 0);
    chk("mid_rst_dout", int'(dout), 16);
    chk("mid_rst_cfg_ready", int'(cfg_ready), 1);
    chk("mid_rst_exp_cx", int'(exp_cx), 0);
    reset = 1'b0;
    repeat (FRAME_CYC + 100) @(negedge clk);
    chk("post_rst_exp_count", int'(exp_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
